// File: rtl/cam_pattern_gen_pkg.sv
// Shared encodings and colour helpers for the camera pattern generator.
// Used by both the top and the pixel formatter.
package cam_gen_pkg;

  typedef enum logic [1:0] {
    MODE_SOLID   = 2'd0,
    MODE_VSTRIPE = 2'd1,
    MODE_HBAND   = 2'd2,
    MODE_RAMP    = 2'd3
  } mode_e;

  typedef enum logic {
    FMT_RGB444 = 1'b0,
    FMT_RGB565 = 1'b1
  } fmt_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Pattern settings, frozen for the duration of a frame
  typedef struct packed {
    mode_e       mode;
    fmt_e        fmt;
    logic [11:0] color0;
    logic [11:0] color1;
  } cfg_t;

  // Expand {R4,G4,B4} to {R5,G6,B5} by replicating the top bits
  function automatic logic [15:0] rgb444_to_565(input logic [11:0] c);
    logic [3:0] r, g, b;
    r = c[11:8];
    g = c[7:4];
    b = c[3:0];
    return {r, r[3], g, g[3:2], b, b[3]};
  endfunction

endpackage

// File: rtl/cam_px_formatter.sv
// Combinational pixel-to-byte formatter: selects byte0/byte1 of a pixel
// in RGB444 or RGB565 wire format.
module cam_px_formatter
  import cam_gen_pkg::*;
(
  input  logic [11:0] color,
  input  fmt_e        fmt,
  input  logic        byte_sel,
  output logic [7:0]  px_byte
);

  logic [15:0] c565;

  always_comb begin
    c565    = rgb444_to_565(color);
    px_byte = 8'h00;
    if (fmt == FMT_RGB565) px_byte = byte_sel ? c565[7:0] : c565[15:8];
    else                   px_byte = byte_sel ? color[7:0] : {4'h0, color[11:8]};
  end

endmodule

// File: rtl/cam_pattern_gen.sv
// OV7670-style camera source: pclk divider, frame counters, run/idle FSM and
// registered sync/data outputs that only move on pclk falling edges.
module cam_pattern_gen
  import cam_gen_pkg::*;
#(
  parameter int TAM_LINE       = 160,
  parameter int TAM_ROW        = 120,
  parameter int BLACK_TAM_LINE = 4,
  parameter int BLACK_TAM_ROW  = 4,
  parameter int VSYNC_ROWS     = 2,
  parameter int PCLK_DIV       = 2,
  parameter int STRIPE         = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [1:0]  mode,
  input  logic        fmt,
  input  logic [11:0] color0,
  input  logic [11:0] color1,
  output logic        CAM_pclk,
  output logic        CAM_vsync,
  output logic        CAM_href,
  output logic [7:0]  CAM_px_data,
  output logic        frame_done
);

  localparam int LINE_LEN   = 2*TAM_LINE + BLACK_TAM_LINE;
  localparam int FRAME_ROWS = TAM_ROW + BLACK_TAM_ROW;
  localparam int BYTE_W     = $clog2(LINE_LEN);
  localparam int ROW_W      = $clog2(FRAME_ROWS);
  localparam int DIV_W      = (PCLK_DIV > 1) ? $clog2(PCLK_DIV) : 1;

  logic [DIV_W-1:0]  div_q, div_d;
  logic              pclk_q, pclk_d;
  logic              tick;
  state_e            state_q, state_d;
  logic [BYTE_W-1:0] byte_q, byte_d;
  logic [ROW_W-1:0]  row_q, row_d;
  cfg_t              cfg_q, cfg_d, cfg_in;
  logic              done_q, done_d;
  logic              vsync_q, vsync_d;
  logic              href_q, href_d;
  logic [7:0]        data_q, data_d;
  logic              line_end, frame_end, run_d;
  logic [15:0]       px, ar;
  logic [11:0]       colour;
  logic [7:0]        fmt_byte;

  // pclk divider; tick marks the clk edge on which pclk falls
  always_comb begin
    div_d  = div_q + DIV_W'(1);
    pclk_d = pclk_q;
    if (div_q == DIV_W'(PCLK_DIV-1)) begin
      div_d  = '0;
      pclk_d = ~pclk_q;
    end
  end

  assign tick = pclk_q && (div_q == DIV_W'(PCLK_DIV-1));

  always_comb begin
    cfg_in.mode   = mode_e'(mode);
    cfg_in.fmt    = fmt_e'(fmt);
    cfg_in.color0 = color0;
    cfg_in.color1 = color1;
  end

  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    row_d     = row_q;
    cfg_d     = cfg_q;
    done_d    = 1'b0;
    line_end  = (byte_q == BYTE_W'(LINE_LEN-1));
    frame_end = line_end && (row_q == ROW_W'(FRAME_ROWS-1));
    if (tick) begin
      unique case (state_q)
        ST_IDLE: begin
          if (en) begin
            state_d = ST_RUN;
            byte_d  = '0;
            row_d   = '0;
            cfg_d   = cfg_in;
          end
        end
        ST_RUN: begin
          byte_d = line_end ? '0 : byte_q + BYTE_W'(1);
          if (line_end) row_d = frame_end ? '0 : row_q + ROW_W'(1);
          if (frame_end) begin
            done_d = 1'b1;
            if (en) cfg_d   = cfg_in;
            else    state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs describe the position the counters are moving to on this tick
  always_comb begin
    run_d  = (state_d == ST_RUN);
    px     = 16'(byte_d >> 1);
    ar     = 16'(row_d) - 16'(BLACK_TAM_ROW);
    colour = cfg_d.color0;
    unique case (cfg_d.mode)
      MODE_SOLID:   colour = cfg_d.color0;
      MODE_VSTRIPE: colour = (((px / 16'(STRIPE)) & 16'd1) != 16'd0) ? cfg_d.color1 : cfg_d.color0;
      MODE_HBAND:   colour = (((ar / 16'(STRIPE)) & 16'd1) != 16'd0) ? cfg_d.color1 : cfg_d.color0;
      MODE_RAMP:    colour = {px[3:0], ar[3:0], ~px[3:0]};
      default:      colour = cfg_d.color0;
    endcase
    vsync_d = run_d && (row_d < ROW_W'(VSYNC_ROWS));
    href_d  = run_d && (row_d >= ROW_W'(BLACK_TAM_ROW)) && (byte_d < BYTE_W'(2*TAM_LINE));
    data_d  = href_d ? fmt_byte : 8'h00;
  end

  cam_px_formatter u_fmt (
    .color    (colour),
    .fmt      (cfg_d.fmt),
    .byte_sel (byte_d[0]),
    .px_byte  (fmt_byte)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      pclk_q  <= 1'b0;
      state_q <= ST_IDLE;
      byte_q  <= '0;
      row_q   <= '0;
      cfg_q   <= '0;
      done_q  <= 1'b0;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      div_q   <= div_d;
      pclk_q  <= pclk_d;
      state_q <= state_d;
      byte_q  <= byte_d;
      row_q   <= row_d;
      cfg_q   <= cfg_d;
      done_q  <= done_d;
      if (tick) begin
        vsync_q <= vsync_d;
        href_q  <= href_d;
        data_q  <= data_d;
      end
    end
  end

  assign CAM_pclk    = pclk_q;
  assign CAM_vsync   = vsync_q;
  assign CAM_href    = href_q;
  assign CAM_px_data = data_q;
  assign frame_done  = done_q;

endmodule

// File: tb/tb_cam_pattern_gen.sv
// Scoreboard bench for cam_pattern_gen on a shrunken frame geometry.
module tb_cam_pattern_gen;

  localparam int TL = 8, TR = 4, BTL = 4, BTR = 4, VS = 2, DIV = 2, STR = 2;
  localparam int LINE_LEN  = 2*TL + BTL;
  localparam int FRAME_CLK = LINE_LEN * (TR + BTR) * 2 * DIV;

  typedef struct packed {
    logic [1:0]  mode;
    logic        fmt;
    logic [11:0] c0;
    logic [11:0] c1;
    logic [7:0]  a0, a1, b0, b1;
  } vec_t;

  // Hand-computed byte pairs: a0/a1 for colour0 pixels, b0/b1 for colour1
  localparam vec_t VEC [8] = '{
    '{2'd0, 1'b0, 12'h00F, 12'h000, 8'h00, 8'h0F, 8'h00, 8'h00},
    '{2'd1, 1'b0, 12'h00F, 12'h0F0, 8'h00, 8'h0F, 8'h00, 8'hF0},
    '{2'd0, 1'b1, 12'hF00, 12'h000, 8'hF8, 8'h00, 8'h00, 8'h00},
    '{2'd0, 1'b1, 12'h0F0, 12'h000, 8'h07, 8'hE0, 8'h00, 8'h00},
    '{2'd2, 1'b0, 12'h123, 12'h456, 8'h01, 8'h23, 8'h04, 8'h56},
    '{2'd3, 1'b0, 12'h000, 12'h000, 8'h00, 8'h00, 8'h00, 8'h00},
    '{2'd1, 1'b1, 12'hF00, 12'h0F0, 8'hF8, 8'h00, 8'h07, 8'hE0},
    '{2'd0, 1'b0, 12'hFFF, 12'h000, 8'h0F, 8'hFF, 8'h00, 8'h00}
  };

  logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0, fmt = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [11:0] color0 = '0, color1 = '0;
  logic        CAM_pclk, CAM_vsync, CAM_href, frame_done;
  logic [7:0]  CAM_px_data;

  int n_chk = 0, n_fail = 0;
  int frames = 0, vrises = 0, pclk_rises = 0;
  logic [7:0] exp_q [$];

  // monitor-private tracking
  logic m_pv = 1'b0, m_ph = 1'b0, m_first_h = 1'b0;
  int   m_vrun = 0, m_hrun = 0, m_since_v = 0;
  logic d_prev = 1'b0, d_have = 1'b0;
  int   d_cyc = 0, d_last = 0;

  always #5 clk = ~clk;
  always @(posedge CAM_pclk) pclk_rises++;

  cam_pattern_gen #(
    .TAM_LINE(TL), .TAM_ROW(TR), .BLACK_TAM_LINE(BTL), .BLACK_TAM_ROW(BTR),
    .VSYNC_ROWS(VS), .PCLK_DIV(DIV), .STRIPE(STR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .fmt(fmt),
    .color0(color0), .color1(color1), .CAM_pclk(CAM_pclk), .CAM_vsync(CAM_vsync),
    .CAM_href(CAM_href), .CAM_px_data(CAM_px_data), .frame_done(frame_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input vec_t v);
    for (int r = 0; r < TR; r++)
      for (int p = 0; p < TL; p++) begin
        logic odd;
        odd = 1'b0;
        if (v.mode == 2'd1) odd = ((p / STR) % 2) == 1;
        if (v.mode == 2'd2) odd = ((r / STR) % 2) == 1;
        if (v.mode == 2'd3) begin
          exp_q.push_back(8'(p & 15));
          exp_q.push_back(8'(((r & 15) << 4) | (~p & 15)));
        end else begin
          exp_q.push_back(odd ? v.b0 : v.a0);
          exp_q.push_back(odd ? v.b1 : v.a1);
        end
      end
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    mode = v.mode; fmt = v.fmt; color0 = v.c0; color1 = v.c1;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while (frame_done !== 1'b1 && n < 3*FRAME_CLK);
    if (frame_done !== 1'b1) check({"timeout_done_", tag}, 0, 1);
  endtask

  task automatic wait_href(input int k);
    int seen = 0, n = 0;
    logic p;
    p = CAM_href;
    while (seen < k && n < 3*FRAME_CLK) begin
      @(negedge clk); n++;
      if (CAM_href && !p) seen++;
      p = CAM_href;
    end
    if (seen < k) check("timeout_href", seen, k);
  endtask

  // Pixel-stream monitor: sampled just after each pclk rising edge
  initial begin
    forever begin
      @(posedge CAM_pclk or negedge rst_n);
      if (!rst_n) begin
        m_pv = 0; m_ph = 0; m_first_h = 0; m_vrun = 0; m_hrun = 0; m_since_v = 0;
      end else begin
        #1;
        if (CAM_href) begin
          if (exp_q.size() == 0) check("href_unexpected", 1, 0);
          else check("px_byte", CAM_px_data, exp_q.pop_front());
        end else begin
          check("data_blank", CAM_px_data, 0);
        end
        if (CAM_vsync && !m_pv) begin vrises++; m_since_v = 0; m_first_h = 1; end
        else m_since_v++;
        if (CAM_vsync) m_vrun++;
        else if (m_pv) begin check("vsync_len", m_vrun, VS*LINE_LEN); m_vrun = 0; end
        if (CAM_href && !m_ph && m_first_h) begin
          check("vsync_to_href", m_since_v, BTR*LINE_LEN);
          m_first_h = 0;
        end
        if (CAM_href) m_hrun++;
        else if (m_ph) begin check("href_len", m_hrun, 2*TL); m_hrun = 0; end
        m_pv = CAM_vsync;
        m_ph = CAM_href;
      end
    end
  end

  // frame_done monitor: one-clk width and fixed period
  initial begin
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        d_prev = 0; d_have = 0; d_cyc = 0;
      end else begin
        d_cyc++;
        if (d_prev) check("done_width", frame_done, 0);
        if (frame_done) begin
          frames++;
          if (d_have) check("done_period", d_cyc - d_last, FRAME_CLK);
          d_have = 1; d_last = d_cyc;
        end
        d_prev = frame_done;
      end
    end
  end

  initial begin
    #(20000 * 10);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pc0, vr0;
    repeat (3) @(negedge clk);
    check("rst_pclk", CAM_pclk, 0);
    check("rst_vsync", CAM_vsync, 0);
    check("rst_href", CAM_href, 0);
    check("rst_data", CAM_px_data, 0);
    check("rst_done", frame_done, 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_vsync", CAM_vsync, 0);

    // Each new config lands mid-frame and must only show up in the next frame
    apply(VEC[0]); en = 1'b1; push_frame(VEC[0]);
    for (int i = 1; i < 7; i++) begin
      wait_href(2);
      apply(VEC[i]);
      push_frame(VEC[i]);
      wait_done("run");
    end
    wait_href(2);
    @(negedge clk) en = 1'b0;
    wait_done("last");
    check("queue_drained", exp_q.size(), 0);

    pc0 = pclk_rises; vr0 = vrises;
    repeat (400) @(negedge clk);
    check("idle_pclk_rises", pclk_rises - pc0, 100);
    check("idle_no_vsync", vrises - vr0, 0);
    check("idle_href", CAM_href, 0);
    check("frames", frames, 7);
    check("vsync_frames", vrises, 7);

    // Reset in the middle of an active line, then restart from row 0
    apply(VEC[7]); en = 1'b1; push_frame(VEC[7]);
    wait_href(1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_pclk", CAM_pclk, 0);
    check("arst_href", CAM_href, 0);
    check("arst_data", CAM_px_data, 0);
    check("arst_vsync", CAM_vsync, 0);
    check("arst_done", frame_done, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    push_frame(VEC[7]);
    wait_done("restart");
    check("restart_drained", exp_q.size(), 0);
    check("restart_frames", frames, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cam_pattern_gen.md
# cam_pattern_gen

Synthesizable, parametrised OV7670-style camera source. It produces CAM_pclk, CAM_vsync, CAM_href and CAM_px_data from the system clock, with programmable frame geometry, pixel format and test pattern. It sits in place of the physical camera in front of the capture block, on the FPGA or in simulation. It can drive full-frame regression against the VGA path without a sensor attached.

## Interface
- TAM_LINE, 160, active pixels per line (bytes per line = 2*TAM_LINE)
- TAM_ROW, 120, active rows per frame
- BLACK_TAM_LINE, 4, blank pclk periods after each line's active bytes
- BLACK_TAM_ROW, 4, blank rows at frame start (href never asserted)
- VSYNC_ROWS, 2, rows with CAM_vsync high at frame start; must be < BLACK_TAM_ROW
- PCLK_DIV, 2, clk cycles per CAM_pclk half-period; >= 1
- STRIPE, 2, stripe width in pixels (mode 1) or rows (mode 2)
- clk  in  1  system clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  run request
- mode  in  2  0 solid color0; 1 vertical stripes; 2 horizontal bands; 3 ramp
- fmt  in  1  0 RGB444; 1 RGB565
- color0  in  12  RGB444 colour {R,G,B}
- color1  in  12  RGB444 colour {R,G,B}
- CAM_pclk  out  1  generated pixel clock (registered, 50% duty)
- CAM_vsync  out  1  frame sync, active high
- CAM_href  out  1  line valid
- CAM_px_data  out  8  pixel byte
- frame_done  out  1  one-clk pulse at end of each frame

## Operation
- States are IDLE and RUN. Reset enters IDLE.
- IDLE: CAM_pclk keeps toggling. vsync, href and data are held at 0. When en=1 is seen at a pclk falling edge, enter RUN with byte_cnt=row_cnt=0.
- On entry to RUN and at every frame start, latch mode, fmt, color0 and color1. Changes mid-frame take effect at the next frame.
- Counters advance on each CAM_pclk falling edge (tick):
  - byte_cnt wraps at 2*TAM_LINE+BLACK_TAM_LINE-1 and increments row_cnt.
  - row_cnt wraps at TAM_ROW+BLACK_TAM_ROW-1. This is the frame end.
- CAM_vsync = (row_cnt < VSYNC_ROWS).
- CAM_href = (row_cnt >= BLACK_TAM_ROW) && (byte_cnt < 2*TAM_LINE).
- Pixel index px = byte_cnt>>1. Active row index ar = row_cnt-BLACK_TAM_ROW.
- Colour selection by mode:
  - mode 0: color0.
  - mode 1: (px/STRIPE) even gives color0, odd gives color1.
  - mode 2: the same rule applied to ar.
  - mode 3: {px[3:0], ar[3:0], ~px[3:0]}.
- Byte format:
  - RGB444: byte0={4'h0,R}, byte1={G,B}.
  - RGB565: expand by bit replication R5={R,R[3]}, G6={G,G[3:2]}, B5={B,B[3]}. Then byte0={R5,G6[5:3]}, byte1={G6[2:0],B5}.
- CAM_px_data is 0 whenever href is low.
- en=0 during RUN: the current frame completes, then the block returns to IDLE. frame_done still pulses.
- Counter widths: $clog2 of the respective totals. No overflow is possible under the wrap rules.

## Timing
- Reset values: CAM_pclk=0, CAM_vsync=0, CAM_href=0, CAM_px_data=8'h00, frame_done=0, counters 0, state IDLE.
- CAM_pclk period is 2*PCLK_DIV clk cycles.
- vsync, href and data are registered. They change only in the clk cycle in which CAM_pclk falls, so they are stable at every rising edge.
- First byte latency: the first RUN tick with row_cnt=BLACK_TAM_ROW and byte_cnt=0 drives href=1 and byte0 together.
- frame_done is high for exactly one clk, in the tick at which row_cnt and byte_cnt both wrap.
- rst_n assertion mid-frame forces all outputs to their reset values immediately (asynchronous). Release is synchronous to clk.
- Line length is 2*TAM_LINE+BLACK_TAM_LINE pclk periods. Frame length is that value times (TAM_ROW+BLACK_TAM_ROW).

## Structure
- Package cam_gen_pkg holds:
  - mode encodings MODE_SOLID, MODE_VSTRIPE, MODE_HBAND, MODE_RAMP;
  - format encodings FMT_RGB444, FMT_RGB565;
  - function rgb444_to_565.
- Sub-module cam_px_formatter: combinational, (colour, fmt, byte_sel) -> 8-bit byte.
- The top module holds the pclk divider, counters, FSM and output registers.

## Test plan
- Defaults, mode 0, fmt 0, color0=12'h00F:
  - each active line is 320 bytes alternating 8'h00/8'h0F with href high for 320 pclk and low for 4;
  - vsync high for the first 648 pclk.
- mode 1, STRIPE=2, color0=12'h00F, color1=12'h0F0: line bytes repeat 00 0F 00 0F 00 F0 00 F0.
- fmt 1, mode 0, color0=12'hF00: bytes F8 00 repeated. With color0=12'h0F0: bytes 07 E0.
- Frame count: frame_done pulses every 124*324=40176 pclk (160704 clk at PCLK_DIV=2).
- mode changed from 0 to 1 at row 60: the rest of the frame stays solid and the next frame is striped. en dropped at row 60: the frame finishes, then vsync, href and data stay 0.
- rst_n pulsed low mid-line: all outputs drop to 0 within the same clk. After release and en=1, the frame restarts at row 0.
